i2s_tx: RTL
===========

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter BCLK_DIV, default 32: clk cycles per bclk half-period (minimum 2).
REQ-002 SHALL have parameter SAMPLE_W, default 24: bits per channel word.
REQ-003 SHALL have port clk, input, 1: system clock (100 MHz); the only clock.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port enable, input, 1: start/continue streaming frames.
REQ-006 SHALL have port in_valid, input, 1: stereo pair offered.
REQ-007 SHALL have port in_ready, output, 1: holding register empty, pair accepted when in_valid and in_ready are both high.
REQ-008 SHALL have ports in_left and in_right, input, SAMPLE_W each: pair data, two's complement.
REQ-009 SHALL have port ac_bclk, output, 1: bit clock to codec.
REQ-010 SHALL have port ac_lrclk, output, 1: word select; low = left, high = right.
REQ-011 SHALL have port ac_dac_sdata, output, 1: serial data, MSB first.
REQ-012 SHALL have port underrun, output, 1: one-clk pulse at a frame start with no pair held.

Function
REQ-013 SHALL run a divider counter 0..BCLK_DIV-1 that toggles ac_bclk on wrap while state != IDLE; ac_bclk is held low in IDLE.
REQ-014 SHALL update ac_dac_sdata and ac_lrclk only in the clk cycle where ac_bclk goes 1->0, so the codec samples on the bclk rising edge.
REQ-015 SHALL use left-justified framing with no delay: the channel MSB appears on the same falling edge where ac_lrclk changes; there are exactly SAMPLE_W bclk periods per channel and 2*SAMPLE_W per frame.
REQ-016 SHALL implement the FSM IDLE -> LEFT -> RIGHT -> LEFT ...
  - IDLE -> LEFT: on enable.
  - LEFT -> RIGHT: after SAMPLE_W bits.
  - RIGHT -> LEFT: after SAMPLE_W bits if enable is high.
  - RIGHT -> IDLE: after SAMPLE_W bits if enable is low. Deasserting enable mid-frame always completes the frame.
REQ-017 SHALL hold accepted pairs in a 1-entry holding register; in_ready = !hold_full && !rst.
REQ-018 SHALL transfer the held pair to the shift registers at each frame start (entry to LEFT) and free the holding register in that same cycle; a simultaneous in_valid is not accepted until the next cycle.
REQ-019 SHALL, when a frame starts with the holding register empty, transmit zeros for both channels and pulse underrun for one clk.
REQ-020 SHALL keep in_ready high in IDLE while the holding register is empty, so a pair can be preloaded before enable.
REQ-021 SHALL drive ac_lrclk high in IDLE, so the first LEFT entry produces a falling edge on ac_lrclk.

Reset
REQ-022 SHALL set, while rst is high: state=IDLE, ac_bclk=0, ac_lrclk=1, ac_dac_sdata=0, underrun=0, in_ready=0, holding register empty, divider=0, bit counter=0.
REQ-023 SHALL, on reset asserted mid-frame, take reset values on the next clk edge with no partial frame completion; the pending pair is discarded.

Configuration
REQ-024 SHALL, when I2S_TX_UNDERRUN_CNT_EN is defined, add output underrun_cnt[15:0], which increments on every underrun pulse, saturates at 16'hFFFF, and is cleared by rst.
REQ-025 SHALL, when I2S_TX_UNDERRUN_CNT_EN is undefined, omit the underrun_cnt port and all counter logic; underrun is still generated.

Structure
REQ-026 SHALL take SAMPLE_W default (24), the FSM state encoding (IDLE/LEFT/RIGHT) and the BCLK_DIV default from shared package i2s_pkg.
REQ-027 SHALL instantiate one sub-module, i2s_bclk_gen, containing the divider, ac_bclk and a one-clk falling-edge strobe; FSM, shift registers and handshake stay in i2s_tx.

Verification
REQ-028 Preload L=24'hA5A5A5, R=24'h123456, then enable -> monitor shifting on bclk rising edges captures left=A5A5A5 at lrclk rise and right=123456 at lrclk fall; no underrun.
REQ-029 Defaults, enable held high -> bclk period = 64 clk; lrclk period = 3072 clk; lrclk edges coincide with bclk falling edges.
REQ-030 Enable with no data -> both channels 24'h000000; underrun pulses once per 3072 clk; underrun_cnt reaches 3 after 3 frames (macro defined).
REQ-031 Back-to-back pairs (1,2) then (3,4) -> second pair accepted only the clk after frame start; frames carry (1,2) then (3,4) with no underrun between them.
REQ-032 rst pulsed mid-LEFT at bit 10 -> next clk: bclk=0, lrclk=1, sdata=0, state IDLE; after release, in_ready=1.
REQ-033 Enable dropped at bit 5 of RIGHT -> remaining 19 bits still sent, then IDLE with bclk held low.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: definitions shared by the I2S transmitter slice.
//   BCLK_DIV_DEF : default clk cycles per bclk half-period
//   SAMPLE_W_DEF : default bits per channel word
//   i2s_state_t  : transmitter frame state (IDLE / LEFT / RIGHT)
package i2s_pkg;

    localparam int unsigned BCLK_DIV_DEF = 32;
    localparam int unsigned SAMPLE_W_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } i2s_state_t;

endpackage

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: stereo sample stream into the I2S transmitter.
//   in_valid  : pair offered (master -> slave)
//   in_ready  : holding register empty (slave -> master)
//   in_left   : left channel word, two's complement
//   in_right  : right channel word, two's complement
// A pair transfers on a clk edge where in_valid and in_ready are both high.
interface i2s_tx_if import i2s_pkg::*; #(
    parameter int unsigned SAMPLE_W = SAMPLE_W_DEF
) ();

    logic                in_valid;
    logic                in_ready;
    logic [SAMPLE_W-1:0] in_left;
    logic [SAMPLE_W-1:0] in_right;

    modport master (
        output in_valid,
        output in_left,
        output in_right,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_left,
        input  in_right,
        output in_ready
    );

endinterface

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: bit clock divider for the I2S transmitter.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   run      : transmitter active; when low, divider and ac_bclk are held at 0
//   ac_bclk  : bit clock, toggles every BCLK_DIV clk cycles while running
//   fall_stb : high in the clk cycle whose closing edge takes ac_bclk 1->0
module i2s_bclk_gen import i2s_pkg::*; #(
    parameter int unsigned BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic ac_bclk,
    output logic fall_stb
);

    localparam int unsigned CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic          wrap;

    assign wrap = (div_cnt == CW'(BCLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            div_cnt <= '0;
            ac_bclk <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            ac_bclk <= ~ac_bclk;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    // Strobe leads the falling edge by one cycle so the consumer's registers
    // change on the same clk edge as ac_bclk.
    assign fall_stb = run && ac_bclk && wrap;

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S (left-justified, no delay) stereo DAC transmitter.
//   clk          : system clock, the only clock
//   rst          : synchronous active-high reset
//   enable       : start/continue streaming frames; a frame in progress completes
//   in_if        : i2s_tx_if slave (in_valid / in_ready / in_left / in_right)
//   ac_bclk      : bit clock to codec (low while idle)
//   ac_lrclk     : word select, low = left, high = right (high while idle)
//   ac_dac_sdata : serial data, MSB first, changes on ac_bclk falling edges
//   underrun     : one-clk pulse when a frame starts with no pair held
//   underrun_cnt : saturating count of underrun pulses
//                  (only when I2S_TX_UNDERRUN_CNT_EN is defined)
module i2s_tx import i2s_pkg::*; #(
    parameter int unsigned BCLK_DIV = BCLK_DIV_DEF,
    parameter int unsigned SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    i2s_tx_if.slave     in_if,
    output logic        ac_bclk,
    output logic        ac_lrclk,
    output logic        ac_dac_sdata,
    output logic        underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_cnt
`endif
);

    localparam int unsigned BW = $clog2(SAMPLE_W);
    localparam int unsigned PW = 2 * SAMPLE_W;

    i2s_state_t    state;
    logic [BW-1:0] bit_cnt;
    logic [PW-1:0] shreg;       // {left, right}, shifted out MSB first
    logic [PW-1:0] hold_pair;
    logic          hold_full;
    logic [PW-1:0] next_pair;
    logic          fall_stb;
    logic          run;
    logic          accept;
    logic          last_bit;
    logic          frame_start;

    assign run          = (state != ST_IDLE);
    assign in_if.in_ready = !hold_full && !rst;
    assign accept       = in_if.in_valid && in_if.in_ready;
    assign last_bit     = (bit_cnt == BW'(SAMPLE_W - 1));
    assign frame_start  = enable && ((state == ST_IDLE) ||
                          (state == ST_RIGHT && fall_stb && last_bit));
    assign next_pair    = hold_full ? hold_pair : '0;

    i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .ac_bclk  (ac_bclk),
        .fall_stb (fall_stb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            hold_pair    <= '0;
            hold_full    <= 1'b0;
            ac_lrclk     <= 1'b1;
            ac_dac_sdata <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            underrun <= 1'b0;

            if (accept) begin
                hold_pair <= {in_if.in_left, in_if.in_right};
            end

            // Accept can only coincide with a frame start when the holding
            // register was already empty, so it simply refills it.
            if (accept) begin
                hold_full <= 1'b1;
            end else if (frame_start) begin
                hold_full <= 1'b0;
            end

            if (frame_start) begin
                state        <= ST_LEFT;
                bit_cnt      <= '0;
                ac_lrclk     <= 1'b0;
                ac_dac_sdata <= next_pair[PW-1];
                shreg        <= {next_pair[PW-2:0], 1'b0};
                underrun     <= !hold_full;
            end else if (fall_stb) begin
                ac_dac_sdata <= shreg[PW-1];
                shreg        <= {shreg[PW-2:0], 1'b0};
                if (last_bit) begin
                    bit_cnt  <= '0;
                    ac_lrclk <= 1'b1;
                    if (state == ST_LEFT) begin
                        state <= ST_RIGHT;
                    end else begin
                        state        <= ST_IDLE;
                        ac_dac_sdata <= 1'b0;
                    end
                end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (underrun && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule
